// File: rtl/divider_pkg.sv
// Shared definitions for the integer-N divider built from the ÷3/÷4 prescaler
// and the program/swallow counter pair.
package divider_pkg;

   localparam int DEF_P_W   = 6;
   localparam int DEF_P_RST = 8;
   localparam int DEF_S_RST = 0;

   typedef logic [DEF_P_W-1:0] cnt_t;

endpackage

// File: rtl/swallow_down_cnt.sv
// Loadable down counter used for both the program (P) and swallow (S) counts.
// Load has priority over the decrement enable; the zero flag is combinational.
module swallow_down_cnt
   import divider_pkg::*;
#(
   parameter int W = DEF_P_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_val;
      else if (i_en)
         r_cnt <= r_cnt - W'(1);
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_swallow_counter.sv
// Program/swallow counter pair driving the ÷3/÷4 prescaler modulus input.
// Optional config legality check: define PULSE_SWALLOW_CFG_CHECK_EN.
module pulse_swallow_counter
   import divider_pkg::*;
#(
   parameter int P_W   = DEF_P_W,
   parameter int P_RST = DEF_P_RST,
   parameter int S_RST = DEF_S_RST
) (
   input  logic           clk_in,
   input  logic           rst,
   input  logic [P_W-1:0] cfg_p,
   input  logic [P_W-1:0] cfg_s,
   input  logic           cfg_load,
   output logic           mod,
   output logic           div_out,
   output logic           cfg_err
);

   localparam logic [P_W-1:0] L_P_RST = P_W'(P_RST);
   localparam logic [P_W-1:0] L_S_RST = P_W'(S_RST);

   logic [P_W-1:0] w_p_cnt;
   logic [P_W-1:0] w_s_cnt;
   logic           w_p_zero;
   logic           w_s_zero;
   logic           w_bnd;
   logic           w_cfg_acc;
   logic [P_W-1:0] r_pend_p;
   logic [P_W-1:0] r_pend_s;
   logic           r_mod;
   logic           r_div;

   // A frame boundary is any edge on which the program count has run out.
   assign w_bnd = w_p_zero;

   swallow_down_cnt #(.W(P_W)) u_p_cnt (
      .i_clk  (clk_in),
      .i_rst  (rst),
      .i_load (w_bnd),
      .i_val  (r_pend_p - P_W'(1)),
      .i_en   (1'b1),
      .o_cnt  (w_p_cnt),
      .o_zero (w_p_zero)
   );

   swallow_down_cnt #(.W(P_W)) u_s_cnt (
      .i_clk  (clk_in),
      .i_rst  (rst),
      .i_load (w_bnd),
      .i_val  (r_pend_s),
      .i_en   (!w_s_zero),
      .o_cnt  (w_s_cnt),
      .o_zero (w_s_zero)
   );

`ifdef PULSE_SWALLOW_CFG_CHECK_EN
   logic r_cfg_err;

   assign w_cfg_acc = (cfg_p != '0) && (cfg_s <= cfg_p);

   always_ff @(posedge clk_in) begin
      if (rst)
         r_cfg_err <= 1'b0;
      else
         r_cfg_err <= cfg_load && !w_cfg_acc;
   end

   assign cfg_err = r_cfg_err;
`else
   assign w_cfg_acc = 1'b1;
   assign cfg_err   = 1'b0;
`endif

   // Pending config is only consumed at a boundary, so a load never disturbs a running frame.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_pend_p <= L_P_RST;
         r_pend_s <= L_S_RST;
      end else if (cfg_load && w_cfg_acc) begin
         r_pend_p <= cfg_p;
         r_pend_s <= cfg_s;
      end
   end

   // mod looks one cycle ahead of the swallow count so it is a clean flop output.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_mod <= 1'b1;
         r_div <= 1'b0;
      end else if (w_bnd) begin
         r_mod <= (r_pend_s != '0);
         r_div <= 1'b1;
      end else begin
         r_mod <= (w_s_cnt > P_W'(1));
         r_div <= 1'b0;
      end
   end

   assign mod     = r_mod;
   assign div_out = r_div;

endmodule

// File: tb/tb_pulse_swallow_counter.sv
// Directed bench for pulse_swallow_counter: per-cycle expectations are queued
// as stimulus is driven and compared one cycle later.
module tb_pulse_swallow_counter;
   import divider_pkg::*;

`ifdef PULSE_SWALLOW_CFG_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct packed {
      logic m;
      logic d;
      logic e;
   } exp_t;

   logic clk_in = 1'b0;
   logic rst;
   cnt_t cfg_p;
   cnt_t cfg_s;
   logic cfg_load;
   logic mod;
   logic div_out;
   logic cfg_err;

   exp_t q[$];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   int   n_acc  = 0;

   pulse_swallow_counter dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .cfg_p    (cfg_p),
      .cfg_s    (cfg_s),
      .cfg_load (cfg_load),
      .mod      (mod),
      .div_out  (div_out),
      .cfg_err  (cfg_err)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
      checks++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s cyc=%0d: observed %0d expected %0d", tag, cyc, obs, want);
      end
   endtask

   // Advance one clk_in edge and compare outputs against the oldest expectation.
   task automatic step();
      exp_t e;
      @(posedge clk_in);
      #1;
      cyc++;
      n_acc += mod ? 4 : 3;
      if (q.size() == 0) begin
         checks++;
         fails++;
         $display("FAIL scoreboard_empty cyc=%0d: observed 0 entries expected 1", cyc);
      end else begin
         e = q.pop_front();
         chk("mod", {7'd0, mod}, {7'd0, e.m});
         chk("div_out", {7'd0, div_out}, {7'd0, e.d});
         chk("cfg_err", {7'd0, cfg_err}, {7'd0, e.e});
      end
   endtask

   // Run cyc_n cycles of a frame with program p / swallow s; optionally pulse
   // cfg_load with (np, ns) so that it is sampled on edge load_at of this frame.
   task automatic run_frame(input int p, input int s, input int cyc_n,
                            input int load_at, input int np, input int ns,
                            input int want_n);
      exp_t e;
      n_acc = 0;
      for (int k = 0; k < cyc_n; k++) begin
         if (k == load_at) begin
            cfg_p    = cnt_t'(np);
            cfg_s    = cnt_t'(ns);
            cfg_load = 1'b1;
         end
         e.m = (s >= p) ? 1'b1 : (k < s);
         e.d = (k == 0);
         e.e = CHK && (k == load_at) && ((np == 0) || (ns > np));
         q.push_back(e);
         step();
         cfg_load = 1'b0;
      end
      if (want_n != 0)
         chk("prescaler_N", 8'(n_acc), 8'(want_n));
   endtask

   initial begin
      exp_t e;
      rst      = 1'b1;
      cfg_p    = '0;
      cfg_s    = '0;
      cfg_load = 1'b0;

      // Reset held for three cycles
      e = '{m: 1'b1, d: 1'b0, e: 1'b0};
      repeat (3) begin
         q.push_back(e);
         step();
      end
      rst = 1'b0;

      // Default config P=8, S=0
      run_frame(8, 0, 8, -1, 0, 0, 24);
      run_frame(8, 0, 8, -1, 0, 0, 24);

      // Load P=4,S=2 on the boundary edge: applies one frame later
      run_frame(8, 0, 8, 0, 4, 2, 24);
      run_frame(4, 2, 4, -1, 0, 0, 14);
      run_frame(4, 2, 4, -1, 0, 0, 14);

      // Mid-frame load P=5,S=1: current frame completes with old config
      run_frame(4, 2, 4, 2, 5, 1, 14);
      run_frame(5, 1, 5, -1, 0, 0, 16);
      run_frame(5, 1, 5, -1, 0, 0, 16);

      // Illegal config P=3,S=5
      run_frame(5, 1, 5, 1, 3, 5, 16);
      if (CHK) begin
         run_frame(5, 1, 5, 0, 4, 2, 16);
      end else begin
         run_frame(3, 5, 3, -1, 0, 0, 12);
         run_frame(3, 5, 3, 0, 4, 2, 12);
      end
      run_frame(4, 2, 4, -1, 0, 0, 14);

      // Reset mid-frame abandons frame and reverts pending config
      run_frame(4, 2, 2, -1, 0, 0, 0);
      rst = 1'b1;
      e = '{m: 1'b1, d: 1'b0, e: 1'b0};
      q.push_back(e);
      step();
      chk("p_cnt_after_rst", 8'(dut.w_p_cnt), 8'd0);
      rst = 1'b0;
      run_frame(8, 0, 8, -1, 0, 0, 24);

      // P=1,S=1: every edge is a boundary, mod stays high
      run_frame(8, 0, 8, 0, 1, 1, 24);
      run_frame(1, 1, 1, -1, 0, 0, 4);
      run_frame(1, 1, 1, -1, 0, 0, 4);
      run_frame(1, 1, 1, -1, 0, 0, 4);

      chk("scoreboard_drained", 8'(q.size()), 8'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
